// File: rtl/tx_pkt_arbiter.sv
// Two-source, packet-granular round-robin arbiter onto a single 10G TX user interface.
// Beats leave one cycle after acceptance; overlong packets are truncated and the rest drained.
module tx_pkt_arbiter #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned BV_W      = 8,
   parameter int unsigned MAX_BEATS = 1200
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s0_en,
   input  logic              s0_sop,
   input  logic              s0_eop,
   input  logic [BV_W-1:0]   s0_byte_vaild,
   output logic              s0_ready,
   input  logic [DATA_W-1:0] s1_data,
   input  logic              s1_en,
   input  logic              s1_sop,
   input  logic              s1_eop,
   input  logic [BV_W-1:0]   s1_byte_vaild,
   output logic              s1_ready,
   input  logic              tx_ready,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_data_en,
   output logic              tx_data_sop,
   output logic              tx_data_eop,
   output logic [BV_W-1:0]   tx_data_byte_vaild,
   output logic              o_trunc,
   output logic [15:0]       o_pkt_cnt0,
   output logic [15:0]       o_pkt_cnt1
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;

   localparam logic [15:0] MAX_CNT = 16'(MAX_BEATS);

   state_t            state;
   logic              last_grant;
   logic              drain_src;
   logic [15:0]       beat_cnt;
   logic [15:0]       pkt_cnt0;
   logic [15:0]       pkt_cnt1;

   logic              req0;
   logic              req1;
   logic              sel1;
   logic              acc;
   logic [DATA_W-1:0] b_data;
   logic              b_sop;
   logic              b_eop;
   logic [BV_W-1:0]   b_bv;
   logic [15:0]       beat_next;
   logic              hit_max;

   assign o_pkt_cnt0 = pkt_cnt0;
   assign o_pkt_cnt1 = pkt_cnt1;

   // In DRAIN the drained source stays ready even if the link is not: its beats are discarded.
   always_comb begin
      req0      = s0_en & s0_sop;
      req1      = s1_en & s1_sop;
      s0_ready  = ((state == GNT0) & tx_ready) | ((state == DRAIN) & ~drain_src);
      s1_ready  = ((state == GNT1) & tx_ready) | ((state == DRAIN) & drain_src);
      sel1      = (state == GNT1) | ((state == DRAIN) & drain_src);
      acc       = sel1 ? (s1_en & s1_ready) : (s0_en & s0_ready);
      b_data    = sel1 ? s1_data       : s0_data;
      b_sop     = sel1 ? s1_sop        : s0_sop;
      b_eop     = sel1 ? s1_eop        : s0_eop;
      b_bv      = sel1 ? s1_byte_vaild : s0_byte_vaild;
      beat_next = beat_cnt + 16'd1;
      hit_max   = (beat_next == MAX_CNT);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         last_grant         <= 1'b1;
         drain_src          <= 1'b0;
         beat_cnt           <= '0;
         pkt_cnt0           <= '0;
         pkt_cnt1           <= '0;
         tx_data            <= '0;
         tx_data_en         <= 1'b0;
         tx_data_sop        <= 1'b0;
         tx_data_eop        <= 1'b0;
         tx_data_byte_vaild <= '0;
         o_trunc            <= 1'b0;
      end else begin
         tx_data_en  <= 1'b0;
         tx_data_sop <= 1'b0;
         tx_data_eop <= 1'b0;
         o_trunc     <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 && (!req1 || last_grant)) begin
                  state      <= GNT0;
                  last_grant <= 1'b0;
                  beat_cnt   <= '0;
               end else if (req1) begin
                  state      <= GNT1;
                  last_grant <= 1'b1;
                  beat_cnt   <= '0;
               end
            end
            GNT0, GNT1: begin
               if (acc) begin
                  beat_cnt           <= beat_next;
                  tx_data            <= b_data;
                  tx_data_en         <= 1'b1;
                  tx_data_sop        <= b_sop;
                  tx_data_eop        <= b_eop | hit_max;
                  tx_data_byte_vaild <= b_bv;
                  o_trunc            <= hit_max & ~b_eop;
                  if (b_eop || hit_max) begin
                     if (sel1) pkt_cnt1 <= pkt_cnt1 + 16'd1;
                     else      pkt_cnt0 <= pkt_cnt0 + 16'd1;
                  end
                  if (b_eop) begin
                     state <= IDLE;
                  end else if (hit_max) begin
                     state     <= DRAIN;
                     drain_src <= sel1;
                  end
               end
            end
            DRAIN: begin
               if (acc) begin
                  beat_cnt <= beat_next;
                  if (b_eop) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Self-checking bench for tx_pkt_arbiter: randomized packets against a packet-level reference model.
module tb_tx_pkt_arbiter;

   localparam int MAXB = 8;

   typedef struct packed {
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [7:0]  bv;
   } beat_t;

   logic        sys_clk;
   logic        rst_n;
   logic [63:0] s0_data, s1_data;
   logic        s0_en, s0_sop, s0_eop, s0_ready;
   logic        s1_en, s1_sop, s1_eop, s1_ready;
   logic [7:0]  s0_byte_vaild, s1_byte_vaild;
   logic        tx_ready;
   logic [63:0] tx_data;
   logic        tx_data_en, tx_data_sop, tx_data_eop;
   logic [7:0]  tx_data_byte_vaild;
   logic        o_trunc;
   logic [15:0] o_pkt_cnt0, o_pkt_cnt1;

   tx_pkt_arbiter #(.DATA_W(64), .BV_W(8), .MAX_BEATS(MAXB)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .s0_data(s0_data), .s0_en(s0_en), .s0_sop(s0_sop), .s0_eop(s0_eop),
      .s0_byte_vaild(s0_byte_vaild), .s0_ready(s0_ready),
      .s1_data(s1_data), .s1_en(s1_en), .s1_sop(s1_sop), .s1_eop(s1_eop),
      .s1_byte_vaild(s1_byte_vaild), .s1_ready(s1_ready),
      .tx_ready(tx_ready), .tx_data(tx_data), .tx_data_en(tx_data_en),
      .tx_data_sop(tx_data_sop), .tx_data_eop(tx_data_eop),
      .tx_data_byte_vaild(tx_data_byte_vaild), .o_trunc(o_trunc),
      .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_chk  = 0;
   int n_pass = 0;

   beat_t q0[$];
   beat_t q1[$];

   // packet-level model: beat index within the current packet, and expected next-cycle output
   int          k [2];
   logic [15:0] exp_cnt [2];
   logic        exp_en, exp_sop, exp_eop, exp_trunc, exp_chk_data, bubble;
   logic [63:0] exp_data;
   logic [7:0]  exp_bv;

   int   cyc;
   int   n_out, n_trunc;
   int   sop_src[$];
   int   sop_cyc[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk(input int src, input logic sop, input logic eop);
      beat_t b;
      b.d   = {8'(src), 24'($urandom), 32'($urandom)};
      b.sop = sop;
      b.eop = eop;
      b.bv  = eop ? 8'($urandom_range(1, 255)) : 8'hFF;
      return b;
   endfunction

   task automatic push_pkt(input int src, input int n, input int extra_sop);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b = mk(src, (i == 0) || (i == extra_sop), i == n - 1);
         if (src == 0) q0.push_back(b);
         else          q1.push_back(b);
      end
   endtask

   task automatic model_reset();
      k[0] = 0; k[1] = 0;
      exp_cnt[0] = '0; exp_cnt[1] = '0;
      exp_en = 0; exp_sop = 0; exp_eop = 0; exp_trunc = 0; exp_chk_data = 1; bubble = 0;
      exp_data = '0; exp_bv = '0;
   endtask

   task automatic accept(input int src, input beat_t b);
      k[src]++;
      if (k[src] <= MAXB) begin
         exp_en    = 1;
         exp_sop   = b.sop;
         exp_eop   = b.eop || (k[src] == MAXB);
         exp_trunc = !b.eop && (k[src] == MAXB);
         exp_data  = b.d;
         exp_bv    = b.bv;
         if (b.eop || k[src] == MAXB) exp_cnt[src] = exp_cnt[src] + 16'd1;
      end else begin
         exp_chk_data = 0;
      end
      if (b.eop) begin
         k[src] = 0;
         bubble = 1;
      end
   endtask

   task automatic cycle(input int want0, input int want1);
      beat_t b;
      logic  a0, a1, drn;
      if (q0.size() != 0) begin
         b = q0[0];
         s0_en = 1; s0_data = b.d; s0_sop = b.sop; s0_eop = b.eop; s0_byte_vaild = b.bv;
      end else begin
         s0_en = 0; s0_sop = 0; s0_eop = 0;
      end
      if (q1.size() != 0) begin
         b = q1[0];
         s1_en = 1; s1_data = b.d; s1_sop = b.sop; s1_eop = b.eop; s1_byte_vaild = b.bv;
      end else begin
         s1_en = 0; s1_sop = 0; s1_eop = 0;
      end
      #1;
      chk("tx_en",  64'(tx_data_en),  64'(exp_en));
      chk("tx_sop", 64'(tx_data_sop), 64'(exp_sop));
      chk("tx_eop", 64'(tx_data_eop), 64'(exp_eop));
      chk("trunc",  64'(o_trunc),     64'(exp_trunc));
      if (exp_chk_data) begin
         chk("tx_data", tx_data, exp_data);
         chk("tx_bv",   64'(tx_data_byte_vaild), 64'(exp_bv));
      end
      chk("cnt0", 64'(o_pkt_cnt0), 64'(exp_cnt[0]));
      chk("cnt1", 64'(o_pkt_cnt1), 64'(exp_cnt[1]));
      chk("rdy_excl", 64'(s0_ready & s1_ready), 64'(0));
      if (bubble) chk("bubble", 64'(s0_ready | s1_ready), 64'(0));
      drn = (k[0] >= MAXB) || (k[1] >= MAXB);
      if (!tx_ready && !drn) chk("rdy_stall", 64'(s0_ready | s1_ready), 64'(0));
      if (want0 >= 0) chk("rdy0", 64'(s0_ready), 64'(want0));
      if (want1 >= 0) chk("rdy1", 64'(s1_ready), 64'(want1));
      if (tx_data_en) n_out++;
      if (o_trunc) n_trunc++;
      if (tx_data_en && tx_data_sop) begin
         sop_src.push_back(int'(tx_data[63:56]));
         sop_cyc.push_back(cyc);
      end
      a0 = s0_en & s0_ready;
      a1 = s1_en & s1_ready;
      exp_en = 0; exp_sop = 0; exp_eop = 0; exp_trunc = 0; exp_chk_data = 1; bubble = 0;
      if (a0) begin b = q0.pop_front(); accept(0, b); end
      if (a1) begin b = q1.pop_front(); accept(1, b); end
      @(posedge sys_clk);
      @(negedge sys_clk);
      cyc++;
   endtask

   task automatic run(input int budget);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
         cycle(-1, -1);
         n++;
      end
      chk("run_budget", 64'(q0.size() + q1.size()), 64'(0));
      for (int i = 0; i < 3; i++) cycle(-1, -1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_en"},   64'(tx_data_en), 64'(0));
      chk({tag, "_sop"},  64'(tx_data_sop), 64'(0));
      chk({tag, "_eop"},  64'(tx_data_eop), 64'(0));
      chk({tag, "_bv"},   64'(tx_data_byte_vaild), 64'(0));
      chk({tag, "_data"}, tx_data, 64'(0));
      chk({tag, "_trunc"}, 64'(o_trunc), 64'(0));
      chk({tag, "_rdy0"}, 64'(s0_ready), 64'(0));
      chk({tag, "_rdy1"}, 64'(s1_ready), 64'(0));
      chk({tag, "_cnt0"}, 64'(o_pkt_cnt0), 64'(0));
      chk({tag, "_cnt1"}, 64'(o_pkt_cnt1), 64'(0));
   endtask

   initial begin
      beat_t b;
      rst_n = 0; tx_ready = 1;
      s0_en = 0; s0_sop = 0; s0_eop = 0; s0_data = '0; s0_byte_vaild = '0;
      s1_en = 0; s1_sop = 0; s1_eop = 0; s1_data = '0; s1_byte_vaild = '0;
      cyc = 0; n_out = 0; n_trunc = 0;
      model_reset();
      repeat (3) @(negedge sys_clk);
      chk_all_zero("reset");
      rst_n = 1;
      @(negedge sys_clk);

      // two 4-beat packets per source, both requesting together: s0,s1,s0,s1 with one bubble
      push_pkt(0, 4, -1); push_pkt(0, 4, -1);
      push_pkt(1, 4, -1); push_pkt(1, 4, -1);
      sop_src.delete(); sop_cyc.delete();
      run(60);
      chk("rr_len", 64'(sop_src.size()), 64'(4));
      for (int i = 0; i < 4; i++)
         if (i < sop_src.size()) chk("rr_order", 64'(sop_src[i]), 64'(i % 2));
      for (int i = 1; i < 4; i++)
         if (i < sop_cyc.size()) chk("rr_gap", 64'(sop_cyc[i] - sop_cyc[i-1]), 64'(5));
      chk("rr_cnt0", 64'(o_pkt_cnt0), 64'(2));
      chk("rr_cnt1", 64'(o_pkt_cnt1), 64'(2));

      // single-beat packet on source 0
      b.d = {8'd0, 24'($urandom), 32'($urandom)}; b.sop = 1; b.eop = 1; b.bv = 8'h0F;
      q0.push_back(b);
      n_out = 0;
      run(10);
      chk("one_beat_out", 64'(n_out), 64'(1));
      chk("one_beat_cnt0", 64'(o_pkt_cnt0), 64'(3));

      // tx_ready low for 3 cycles mid-packet; a stray sop on beat 4 must not re-arbitrate
      push_pkt(0, 6, 3);
      n_out = 0;
      for (int i = 0; i < 14; i++) begin
         tx_ready = !(i >= 3 && i <= 5);
         cycle((i >= 1 && i <= 9 && (i < 3 || i > 5)) ? 1 : 0, 0);
      end
      tx_ready = 1;
      chk("stall_out", 64'(n_out), 64'(6));
      chk("stall_cnt0", 64'(o_pkt_cnt0), 64'(4));

      // 12-beat packet on source 1 truncated at 8 beats, remainder drained
      push_pkt(1, 12, -1);
      n_out = 0; n_trunc = 0;
      for (int i = 0; i < 16; i++) begin
         tx_ready = (i != 10);
         cycle(0, (i == 10) ? 1 : -1);
      end
      tx_ready = 1;
      chk("trunc_q", 64'(q1.size()), 64'(0));
      chk("trunc_out", 64'(n_out), 64'(MAXB));
      chk("trunc_pulses", 64'(n_trunc), 64'(1));
      chk("trunc_cnt1", 64'(o_pkt_cnt1), 64'(3));

      // en without sop in IDLE is not a request
      q1.push_back(mk(1, 0, 0));
      n_out = 0;
      for (int i = 0; i < 4; i++) cycle(0, 0);
      q1.delete();
      cycle(-1, -1);
      chk("nosop_out", 64'(n_out), 64'(0));

      // reset during beat 3 of an s1 packet
      push_pkt(1, 5, -1);
      for (int i = 0; i < 10 && k[1] < 2; i++) cycle(-1, -1);
      chk("pre_rst_beats", 64'(k[1]), 64'(2));
      b = q1[0];
      s1_en = 1; s1_data = b.d; s1_sop = b.sop; s1_eop = b.eop; s1_byte_vaild = b.bv;
      #2;
      rst_n = 0;
      #1;
      chk_all_zero("mid_rst");
      @(posedge sys_clk);
      @(negedge sys_clk);
      rst_n = 1;
      q0.delete(); q1.delete();
      model_reset();
      push_pkt(0, 1, -1); push_pkt(1, 1, -1);
      sop_src.delete(); sop_cyc.delete();
      run(20);
      chk("post_rst_len", 64'(sop_src.size()), 64'(2));
      if (sop_src.size() != 0) chk("post_rst_first", 64'(sop_src[0]), 64'(0));

      // packet counter wrap from 0xFFFF
      force dut.pkt_cnt0 = 16'hFFFF;
      @(posedge sys_clk);
      @(negedge sys_clk);
      release dut.pkt_cnt0;
      exp_cnt[0] = 16'hFFFF;
      #1;
      chk("preset_cnt0", 64'(o_pkt_cnt0), 64'(16'hFFFF));
      push_pkt(0, 2, -1);
      run(10);
      chk("wrap_cnt0", 64'(o_pkt_cnt0), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tx_pkt_arbiter.md
TX_PKT_ARBITER -- requirements
Module: tx_pkt_arbiter

Interface
REQ-001 Parameter: DATA_W, default 64, TX beat data width.
REQ-002 Parameter: BV_W, default 8, byte-valid mask width (DATA_W/8).
REQ-003 Parameter: MAX_BEATS, default 1200, maximum beats per packet before forced truncation.
REQ-004 Port: sys_clk  in  1  single clock; usclk domain of the 10G link.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports, per source i in {0,1}: s<i>_data  in  DATA_W; s<i>_en  in  1; s<i>_sop  in  1; s<i>_eop  in  1; s<i>_byte_vaild  in  BV_W; s<i>_ready  out  1.
REQ-007 Port: tx_ready  in  1  link may accept beats.
REQ-008 Ports: tx_data  out  DATA_W; tx_data_en  out  1; tx_data_sop  out  1; tx_data_eop  out  1; tx_data_byte_vaild  out  BV_W.
REQ-009 Ports: o_trunc  out  1  one-cycle pulse on forced truncation; o_pkt_cnt0, o_pkt_cnt1  out  16  packets forwarded per source.

Function
REQ-010 The block SHALL share one 10G TX user interface between two packet sources, with packet-granular round-robin arbitration.
REQ-011 States SHALL be IDLE, GNT0, GNT1 and DRAIN.
REQ-012 Source i SHALL be requesting when s<i>_en=1 and s<i>_sop=1; en without sop in IDLE is not a request and the beat stays stalled.
REQ-013 In IDLE with exactly one request, the block SHALL enter GNTi for that source on the next cycle.
REQ-014 In IDLE with both requests, the block SHALL grant the source other than last_grant.
REQ-015 last_grant SHALL update on every grant.
REQ-016 s<i>_ready SHALL equal (state==GNTi) AND tx_ready; in DRAIN it SHALL be 1 for the drained source; otherwise it SHALL be 0.
REQ-017 A beat SHALL be accepted when s<i>_en AND s<i>_ready.
REQ-018 Each accepted beat in GNTi SHALL appear on tx_* exactly 1 cycle later (registered), with en=1 and data/sop/eop/byte_vaild unchanged.
REQ-019 The registered output SHALL be emitted regardless of tx_ready (sink tolerates one beat after ready drop).
REQ-020 Cycles with no accepted beat SHALL drive tx_data_en=0, tx_data_sop=0 and tx_data_eop=0; data and byte_vaild SHALL hold their last value.
REQ-021 Accepted eop in GNTi SHALL return the FSM to IDLE, increment o_pkt_cnt<i> (16-bit, wraps 0xFFFF->0) and cause one idle bubble cycle before the next grant.
REQ-022 A 16-bit beat counter SHALL clear on grant and increment per accepted beat.
REQ-023 If the MAX_BEATS-th accepted beat lacks eop, that beat SHALL be output with tx_data_eop forced to 1 and o_trunc pulsed with it.
REQ-024 After a truncation, the FSM SHALL enter DRAIN and the packet counter SHALL still increment.
REQ-025 In DRAIN, beats from the granted source SHALL be accepted and discarded (tx_data_en=0) until its eop is accepted; the FSM SHALL then go to IDLE.
REQ-026 A beat carrying sop while in GNTi or DRAIN (missing eop) SHALL be forwarded or discarded like any other beat; no re-arbitration SHALL occur.
REQ-027 tx_ready deasserting mid-packet SHALL stall the source (ready=0) without releasing the grant.

Reset
REQ-028 While rst_n=0, the block SHALL hold state=IDLE and last_grant=1 (source 0 wins the first tie).
REQ-029 While rst_n=0, tx_data_en, sop, eop, byte_vaild, data, o_trunc, both s<i>_ready, both packet counters and the beat counter SHALL all be 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet with no eop generated; after release, arbitration SHALL restart from IDLE.

Verification
REQ-031 Both sources present a 4-beat packet continuously with tx_ready=1 after reset -> order s0,s1,s0,s1; 1 bubble between packets; each beat is on tx_* 1 cycle after acceptance; cnt0=cnt1 after each pair.
REQ-032 Source 0 only sends a 1-beat packet (sop=eop=1, byte_vaild=0x0F) -> tx_data_en pulses 1 cycle with sop=eop=1 and byte_vaild=0x0F; o_pkt_cnt0=1.
REQ-033 tx_ready low 3 cycles mid-packet -> s0_ready low for exactly those cycles; no beat lost or duplicated; grant held.
REQ-034 MAX_BEATS=8, source 1 sends 12 beats without eop until beat 12 -> 8 beats out, 8th with eop=1 and o_trunc=1; beats 9-12 discarded; then IDLE; o_pkt_cnt1=1.
REQ-035 rst_n pulsed low during beat 3 of a s1 packet -> all outputs 0 immediately; after release, a simultaneous request from both sources grants s0 first.
REQ-036 Preset o_pkt_cnt0=0xFFFF, then one s0 packet -> o_pkt_cnt0=0x0000.
